// File: rtl/gray_stream_monitor.sv
// Gray stream monitor: decodes the upstream Gray count to binary one cycle late and
// checks that each valid sample advances by exactly one step, with a consistent wrap strobe.
module gray_stream_monitor #(
    parameter int CBITS    = 13,
    parameter int LOCK_LEN = 4,
    parameter int ECW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    input  logic             wrap_in,
    input  logic             clr,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             locked,
    output logic             step_err,
    output logic             wrap_err,
    output logic             fault,
    output logic [ECW-1:0]   err_cnt,
    output logic [ECW-1:0]   wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [ECW-1:0] ERR_MAX     = '1;
    localparam logic [3:0]     LOCK_TARGET = 4'(LOCK_LEN);

    state_t           state_q, state_d;
    logic [CBITS-1:0] prev_q, prev_d;
    logic [CBITS-1:0] bin_q;
    logic             bin_vld_q;
    logic [3:0]       run_q, run_d;
    logic             step_err_q, step_err_d;
    logic             wrap_err_q, wrap_err_d;
    logic [ECW-1:0]   err_cnt_q, err_cnt_d;
    logic [ECW-1:0]   wrap_cnt_q, wrap_cnt_d;

    logic [CBITS-1:0] decoded;
    logic [CBITS-1:0] expected;
    logic             rollover;
    logic             step_ok;
    logic             wrap_inc;

    // Each binary bit is the parity of the Gray bits at and above its position.
    always_comb begin
        decoded = '0;
        for (int i = 0; i < CBITS; i++) begin
            decoded[i] = ^(gray_in >> i);
        end
    end

    assign expected = prev_q + CBITS'(1);
    assign rollover = (prev_q == '1) && (decoded == '0);
    assign step_ok  = (decoded == expected);

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        prev_d     = prev_q;
        step_err_d = 1'b0;
        wrap_err_d = 1'b0;
        wrap_inc   = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;

        if (gray_vld) begin
            prev_d   = decoded;
            wrap_inc = rollover && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    run_d   = 4'd0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (step_ok) begin
                        run_d = run_q + 4'd1;
                        if ((run_q + 4'd1) == LOCK_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        step_err_d = 1'b1;
                        run_d      = 4'd0;
                        state_d    = ACQUIRE;
                    end
                    if (rollover != wrap_in) begin
                        wrap_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A simultaneous step and wrap error is one event for the error counter.
        if (clr) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
            if (state_q == FAULT) begin
                state_d = IDLE;
            end
        end else begin
            if ((step_err_d || wrap_err_d) && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + ECW'(1);
            end
            wrap_cnt_d = wrap_cnt_q + ECW'(wrap_inc);
            if (err_cnt_d == ERR_MAX) begin
                state_d = FAULT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            run_q      <= 4'd0;
            bin_q      <= '0;
            bin_vld_q  <= 1'b0;
            step_err_q <= 1'b0;
            wrap_err_q <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            bin_vld_q  <= gray_vld;
            step_err_q <= step_err_d;
            wrap_err_q <= wrap_err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            if (gray_vld) begin
                bin_q <= decoded;
            end
        end
    end

    assign bin_out  = bin_q;
    assign bin_vld  = bin_vld_q;
    assign locked   = (state_q == LOCKED);
    assign fault    = (state_q == FAULT);
    assign step_err = step_err_q;
    assign wrap_err = wrap_err_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_gray_stream_monitor.sv
// Self-checking bench for gray_stream_monitor: directed scenarios plus a randomized run,
// all compared against a behavioural model of the monitor's rules.
module tb_gray_stream_monitor;

    localparam int CBITS    = 3;
    localparam int LOCK_LEN = 4;
    localparam int ECW      = 2;
    localparam int SPAN     = 1 << CBITS;
    localparam int WSPAN    = 1 << ECW;
    localparam int ERRMAX   = WSPAN - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_LOCK  = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CBITS-1:0] gray_in = '0;
    logic             gray_vld = 1'b0;
    logic             wrap_in = 1'b0;
    logic             clr = 1'b0;
    logic [CBITS-1:0] bin_out;
    logic             bin_vld;
    logic             locked;
    logic             step_err;
    logic             wrap_err;
    logic             fault;
    logic [ECW-1:0]   err_cnt;
    logic [ECW-1:0]   wrap_cnt;

    int checkCount = 0;
    int passCount  = 0;

    int mState, mRun, mPrev, mBin, mBinVld, mStepErr, mWrapErr, mErrCnt, mWrapCnt;
    int lastBin;

    gray_stream_monitor #(
        .CBITS   (CBITS),
        .LOCK_LEN(LOCK_LEN),
        .ECW     (ECW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .gray_vld(gray_vld),
        .wrap_in (wrap_in),
        .clr     (clr),
        .bin_out (bin_out),
        .bin_vld (bin_vld),
        .locked  (locked),
        .step_err(step_err),
        .wrap_err(wrap_err),
        .fault   (fault),
        .err_cnt (err_cnt),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    function automatic int toGray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decoding by search over the encoder keeps the model independent of the XOR chain.
    function automatic int grayToBin(input int g);
        for (int v = 0; v < SPAN; v++) begin
            if (toGray(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = M_IDLE; mRun = 0; mPrev = 0; mBin = 0; mBinVld = 0;
        mStepErr = 0; mWrapErr = 0; mErrCnt = 0; mWrapCnt = 0;
    endtask

    task automatic modelStep(input int g, input bit vld, input bit w, input bit c);
        int d, expv, oldState, wrapInc;
        bit roll, se, we;
        oldState = mState; se = 0; we = 0; wrapInc = 0;
        if (vld) begin
            d    = grayToBin(g);
            expv = (mPrev + 1) % SPAN;
            roll = (mPrev == SPAN - 1) && (d == 0);
            mBin = d;
            mBinVld = 1;
            if (mState == M_IDLE) begin
                mRun = 0;
                mState = M_ACQ;
            end else if (mState == M_ACQ) begin
                if (d == expv) begin
                    mRun++;
                    if (mRun == LOCK_LEN) mState = M_LOCK;
                end else begin
                    mRun = 0;
                end
            end else if (mState == M_LOCK) begin
                if (d != expv) begin
                    se = 1;
                    mRun = 0;
                    mState = M_ACQ;
                end
                if (roll != w) we = 1;
            end
            if (roll && oldState != M_IDLE) wrapInc = 1;
            mPrev = d;
        end else begin
            mBinVld = 0;
        end
        if (c) begin
            mErrCnt = 0;
            mWrapCnt = 0;
            if (oldState == M_FAULT) mState = M_IDLE;
        end else begin
            if ((se || we) && mErrCnt < ERRMAX) mErrCnt++;
            mWrapCnt = (mWrapCnt + wrapInc) % WSPAN;
            if (mErrCnt == ERRMAX) mState = M_FAULT;
        end
        mStepErr = se;
        mWrapErr = we;
    endtask

    task automatic compareModel();
        checkOutput("bin_out",  int'(bin_out),  mBin);
        checkOutput("bin_vld",  int'(bin_vld),  mBinVld);
        checkOutput("locked",   int'(locked),   int'(mState == M_LOCK));
        checkOutput("fault",    int'(fault),    int'(mState == M_FAULT));
        checkOutput("step_err", int'(step_err), mStepErr);
        checkOutput("wrap_err", int'(wrap_err), mWrapErr);
        checkOutput("err_cnt",  int'(err_cnt),  mErrCnt);
        checkOutput("wrap_cnt", int'(wrap_cnt), mWrapCnt);
    endtask

    // Called at a falling edge; the rising edge in between is the one under test.
    task automatic applyStimulus(input int bin, input bit vld, input bit w, input bit c);
        int g;
        g = toGray(bin);
        gray_in  = g[CBITS-1:0];
        gray_vld = vld;
        wrap_in  = w;
        clr      = c;
        modelStep(g, vld, w, c);
        if (vld) lastBin = bin;
        @(negedge clk);
        compareModel();
    endtask

    task automatic asyncReset();
        #2 rst = 1'b1;
        modelReset();
        lastBin = 0;
        #1;
        compareModel();
        @(negedge clk);
        rst = 1'b0;
        compareModel();
    endtask

    initial begin
        int b, r;
        bit v, w, c;
        modelReset();
        lastBin = 0;
        repeat (2) @(negedge clk);
        compareModel();
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;

        // Clean ascending stream: lock rises after the fifth sample.
        for (int k = 0; k < SPAN; k++) begin
            applyStimulus(k, 1'b1, 1'b0, 1'b0);
            checkOutput("seq_bin_out", int'(bin_out), k);
            if (k == 3) checkOutput("seq_not_yet_locked", int'(locked), 0);
            if (k == 4) checkOutput("seq_locked", int'(locked), 1);
        end
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("first_wrap_cnt", int'(wrap_cnt), 1);
        for (int k = 1; k <= 5; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);

        // Gray 3'b110 decodes to 4 while 6 is expected.
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        checkOutput("inject_step_err", int'(step_err), 1);
        checkOutput("inject_err_cnt", int'(err_cnt), 1);
        checkOutput("inject_locked", int'(locked), 0);
        for (int k = 5; k <= 7; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);
        checkOutput("relock_pending", int'(locked), 0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("relock", int'(locked), 1);

        for (int k = 1; k <= 7; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("good_wrap_no_err", int'(wrap_err), 0);
        checkOutput("good_wrap_cnt", int'(wrap_cnt), 3);
        for (int k = 1; k <= 7; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("missing_wrap_err", int'(wrap_err), 1);
        checkOutput("missing_wrap_err_cnt", int'(err_cnt), 2);
        checkOutput("missing_wrap_locked", int'(locked), 1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_err_pulse_end", int'(wrap_err), 0);

        // Gated valid: bin_vld follows the pattern one cycle later, bin_out holds.
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        checkOutput("gated_vld_1", int'(bin_vld), 1);
        applyStimulus(6, 1'b0, 1'b0, 1'b0);
        checkOutput("gated_vld_0", int'(bin_vld), 0);
        checkOutput("gated_hold", int'(bin_out), 2);
        applyStimulus(3, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        checkOutput("gated_no_err", int'(step_err), 0);

        // Clear, then drive three locked step errors into saturation.
        applyStimulus(5, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_err_cnt", int'(err_cnt), 0);
        checkOutput("clr_keeps_lock", int'(locked), 1);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(lastBin, 1'b1, 1'b0, 1'b0);
            if (n < 2) begin
                for (int k = 0; k < LOCK_LEN; k++)
                    applyStimulus((lastBin + 1) % SPAN, 1'b1, 1'b0, 1'b0);
            end
        end
        checkOutput("sat_err_cnt", int'(err_cnt), 3);
        checkOutput("sat_fault", int'(fault), 1);
        applyStimulus(lastBin, 1'b1, 1'b0, 1'b0);
        checkOutput("fault_no_pulse", int'(step_err), 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        checkOutput("fault_clr_cnt", int'(err_cnt), 0);
        checkOutput("fault_clr_fault", int'(fault), 0);
        for (int k = 0; k <= LOCK_LEN; k++)
            applyStimulus((lastBin + 1) % SPAN, 1'b1, 1'b0, 1'b0);
        checkOutput("after_clr_relock", int'(locked), 1);

        // Reset between edges must clear outputs without a clock.
        asyncReset();
        checkOutput("async_locked", int'(locked), 0);
        checkOutput("async_bin_out", int'(bin_out), 0);
        applyStimulus(3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < LOCK_LEN; k++)
            applyStimulus((lastBin + 1) % SPAN, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_lock", int'(locked), 1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            b = (r < 80) ? (lastBin + 1) % SPAN : $urandom_range(0, SPAN - 1);
            v = ($urandom_range(0, 99) < 85);
            w = (b == 0) && (lastBin == SPAN - 1);
            if ($urandom_range(0, 99) < 10) w = !w;
            c = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 999) < 5) begin
                asyncReset();
            end else begin
                applyStimulus(b, v, w, c);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gray_stream_monitor.md
Name: gray_stream_monitor

Overview:
- Downstream consumer of the Gray-code counter stage.
- Samples the counter's Gray output and its wrap strobe, and decodes the Gray value to binary with one cycle of latency.
- Checks that the stream advances by exactly one binary step per valid sample and that the wrap strobe is consistent with the decoded roll-over.
- Reports lock status, error pulses, a saturating error count and a wrap count, for use by system health logic and formal liveness checks.

Parameters:
- CBITS, 13, width of the Gray input and binary output.
- LOCK_LEN, 4, number of consecutive correct +1 steps required to declare lock (allowed range 1..15).
- ECW, 8, width of err_cnt and wrap_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- gray_in  in  CBITS  Gray-coded count from the upstream counter.
- gray_vld  in  1  gray_in and wrap_in are sampled only when this is 1.
- wrap_in  in  1  upstream wrap strobe, aligned with the gray_in sample that decodes to 0.
- clr  in  1  synchronous clear of err_cnt, wrap_cnt and the FAULT state.
- bin_out  out  CBITS  decoded binary value, registered.
- bin_vld  out  1  bin_out valid pulse, one cycle after gray_vld.
- locked  out  1  high while the FSM is in LOCKED.
- step_err  out  1  one-cycle pulse on a sequence violation detected in LOCKED.
- wrap_err  out  1  one-cycle pulse on a wrap_in/roll-over mismatch detected in LOCKED.
- fault  out  1  high while the FSM is in FAULT.
- err_cnt  out  ECW  saturating count of step_err plus wrap_err events.
- wrap_cnt  out  ECW  count of decoded roll-overs; wraps modulo 2^ECW.

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs are 0, FSM goes to IDLE, run counter is 0, prev register is 0.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
- Decode: b[CBITS-1] = g[CBITS-1]; b[i] = b[i+1] ^ g[i].
  - On a cycle with gray_vld=1: bin_out <= decode(gray_in) and bin_vld <= 1.
  - Otherwise: bin_vld <= 0 and bin_out holds its value.
- Let d = decode(gray_in) and p = the previous accepted decoded value.
  - expected = (p + 1) mod 2^CBITS.
  - rollover = (p == all-ones) and (d == 0).
- Samples with gray_vld=0 are ignored entirely: no state change and no check.
- FSM (transitions evaluated only on gray_vld=1 cycles):
  - IDLE:
    - The first valid sample loads p <= d, sets run <= 0 and moves to ACQUIRE.
  - ACQUIRE:
    - If d == expected: run <= run + 1. When run+1 == LOCK_LEN, move to LOCKED.
    - If d != expected: run <= 0 and stay in ACQUIRE.
    - No error pulses or err_cnt increments are issued in this state.
  - LOCKED:
    - If d != expected: step_err = 1, run <= 0, move to ACQUIRE.
    - If rollover != wrap_in: wrap_err = 1, and stay in LOCKED unless a step error occurs on the same sample.
    - If step_err and wrap_err both fire on one sample: both pulses assert and err_cnt increments by 1, not 2.
  - FAULT:
    - Entered from any state when err_cnt reaches 2^ECW - 1.
    - Checks stop: no further error pulses.
    - bin_out and bin_vld keep operating.
    - Leaves only on clr=1 (to IDLE) or on reset.
- p updates to d on every valid sample in every state.
- Error and wrap pulses (step_err, wrap_err, and the wrap_cnt increment) are registered: they appear one cycle after the offending sample, aligned with bin_vld.
- wrap_cnt increments on each rollover in any state except IDLE.
- err_cnt saturates at 2^ECW - 1 and never wraps.
- clr=1:
  - Zeroes err_cnt and wrap_cnt; from FAULT, moves to IDLE.
  - clr has priority over a same-cycle increment.
  - clr does not affect bin_out.
- A repeated sample (d == p) counts as a step violation.

Test Plan:
- Feed Gray 0,1,3,2,6,7,5,4 (CBITS=3, LOCK_LEN=4) with gray_vld=1 every cycle -> bin_out reads 0..7 one cycle later; locked rises one cycle after the 5th sample; no errors.
- While locked at decoded 5, inject Gray 0b110 (decodes to 4) -> step_err pulses once, err_cnt=1, locked drops; after 4 further correct steps, locked=1 again.
- CBITS=3, locked, sequence decodes 6,7,0 with wrap_in=1 on the 0 -> wrap_cnt=1, no wrap_err; repeat with wrap_in=0 -> wrap_err pulse, err_cnt increments, locked stays 1.
- gray_vld toggling 1,0,1,0 across a correct sequence -> no errors, bin_vld mirrors the gated pattern delayed by 1 cycle.
- ECW=2, force 3 step errors -> err_cnt=3, fault=1, further bad samples produce no pulses; pulse clr -> err_cnt=0, fault=0, FSM in IDLE.
- Assert rst asynchronously mid-sequence between clock edges -> all outputs go to 0 immediately; after release, first valid sample re-enters ACQUIRE.
